// File: rtl/ifetch_bridge_pkg.sv
// ifetch_bridge_pkg
// Shared types for the instruction-fetch bridge:
//   word_t          32-bit machine word (PC, address, instruction)
//   ifetch_state_t  bridge sequencing states
//   is_misaligned   true when a fetch address is not word aligned
package ifetch_bridge_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } ifetch_state_t;

    function automatic logic is_misaligned(input word_t addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_bridge_if.sv
// ifetch_bridge_if
// SRAM-like instruction bus between the fetch bridge (master) and the
// instruction memory / cache (slave).
//   inst_req      master -> slave  request valid
//   inst_addr     master -> slave  request address
//   inst_addr_ok  slave  -> master request accepted this cycle
//   inst_data_ok  slave  -> master read data valid this cycle
//   inst_rdata    slave  -> master read data
interface ifetch_bridge_if;
    import ifetch_bridge_pkg::*;

    logic  inst_req;
    word_t inst_addr;
    logic  inst_addr_ok;
    logic  inst_data_ok;
    word_t inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/ifetch_bridge.sv
// ifetch_bridge
// Turns the current fetch PC into a single-outstanding instruction bus
// request, buffers the returned word and presents it to the fetch stage.
// Responses made stale by a redirect are discarded; misaligned PCs are
// flagged without any bus activity.
// Ports:
//   clk            core clock, rising edge
//   resetn         asynchronous active-low reset
//   pc             current fetch PC
//   fetch_en       fetch wanted (only leaves IDLE when high)
//   advance        PC register loads next PC; held instruction consumed
//   flush          redirect; any in-flight or held word is stale
//   bus            instruction bus, master side
//   instr          buffered instruction
//   i_data_ok      instr valid for current pc (stallF = ~i_data_ok)
//   pc_misaligned  the held result is a misaligned-PC fetch
module ifetch_bridge
    import ifetch_bridge_pkg::*;
#(
    parameter word_t RESET_INSTR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           resetn,
    input  word_t          pc,
    input  logic           fetch_en,
    input  logic           advance,
    input  logic           flush,
    ifetch_bridge_if.master bus,
    output word_t          instr,
    output logic           i_data_ok,
    output logic           pc_misaligned
);

    ifetch_state_t state_q, state_d;
    logic          locked_q, locked_d;   // address pinned until accepted
    word_t         req_pc_q, req_pc_d;
    logic          drop_q, drop_d;       // outstanding response is stale
    word_t         instr_q, instr_d;
    logic          pc_mis_q, pc_mis_d;

    logic          req_c;
    word_t         addr_c;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            locked_q <= 1'b0;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
            instr_q  <= RESET_INSTR;
            pc_mis_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            locked_q <= locked_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            instr_q  <= instr_d;
            pc_mis_q <= pc_mis_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        instr_d  = instr_q;
        pc_mis_d = pc_mis_q;
        req_c    = 1'b0;
        // Once a request has been presented but not accepted, the bus
        // address must not move even if the PC register does.
        addr_c   = locked_q ? req_pc_q : pc;

        case (state_q)
            S_IDLE: begin
                if (fetch_en && !flush) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (!locked_q && is_misaligned(pc)) begin
                    // Never put a misaligned address on the bus; hand the
                    // fault straight to fetch as a held result.
                    state_d  = S_HOLD;
                    instr_d  = RESET_INSTR;
                    pc_mis_d = 1'b1;
                end else begin
                    req_c = 1'b1;
                    // A pinned request cannot be withdrawn, so a redirect
                    // only marks its eventual response as stale.
                    if (locked_q && flush) begin
                        drop_d = 1'b1;
                    end
                    if (bus.inst_addr_ok) begin
                        state_d  = S_WAIT;
                        locked_d = 1'b0;
                    end else begin
                        locked_d = 1'b1;
                        req_pc_d = addr_c;
                    end
                end
            end

            S_WAIT: begin
                if (bus.inst_data_ok) begin
                    if (drop_q || flush) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        instr_d = bus.inst_rdata;
                        state_d = S_HOLD;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end

            S_HOLD: begin
                // Flush outranks advance: the held word belongs to the
                // abandoned path.
                if (flush) begin
                    state_d  = S_REQ;
                    instr_d  = RESET_INSTR;
                    pc_mis_d = 1'b0;
                end else if (advance) begin
                    state_d  = S_REQ;
                    pc_mis_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.inst_req  = req_c;
    assign bus.inst_addr = addr_c;

    assign instr         = instr_q;
    assign i_data_ok     = (state_q == S_HOLD);
    assign pc_misaligned = pc_mis_q;

endmodule
